// File: rtl/imem_loader_pkg.sv
// Shared types for the boot image loader: FSM states, frame geometry, byte/word types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    // States in which the loader is willing to take a byte from the link.
    function automatic logic rx_open(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs LSB-first bytes into 32-bit words; word_vld pulses combinationally with the 4th byte.
// Latency: 0 cycles from 4th byte to word_vld/word_dat.
// Backpressure: none; the caller only presents bytes it has already accepted.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_word_vld,
    output logic [31:0] o_word_dat
);

    logic [1:0]  r_cnt;
    logic [23:0] r_sh;

    assign o_word_vld = i_byte_vld && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word_dat = {i_byte_dat, r_sh};

    // Bytes enter at the top so the first byte ends up in the low lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 2'd0;
            r_sh  <= 24'd0;
        end else if (i_clear) begin
            r_cnt <= 2'd0;
            r_sh  <= 24'd0;
        end else if (i_byte_vld) begin
            r_cnt <= r_cnt + 2'd1;
            r_sh  <= {i_byte_dat, r_sh[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte frame (16-bit count + words) -> i_mem writes, CPU held in reset until done; IMEM_LOADER_CSUM_EN adds a trailing XOR byte.
// Latency: write strobe 1 cycle after a word's 4th byte; CPU reset drops 1 cycle after the last write.
// Backpressure: o_rx_ready low during WRITE/DONE/ERR; bytes offered then are left on the link.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    input  logic              i_reload,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [31:0]       o_im_wd,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int N_W   = 8 * HDR_BYTES;

    state_t           r_state;
    state_t           w_nxt;
    byte_t            r_cnt_lo;
    logic [N_W-1:0]   r_n;
    logic [IDX_W-1:0] r_index;
    logic [TO_W-1:0]  r_idle;
    logic             r_rx_ready;
    logic             r_im_we;
    logic             r_cpu_rst;
    logic             r_done;
    logic             r_err;
    word_t            r_im_wd;

    logic             w_acc;
    logic             w_word_vld;
    word_t            w_word;
    logic             w_clear;
    logic             w_counting;
    logic             w_timeout;
    logic             w_last;
    logic [N_W-1:0]   w_n;
    logic             w_csum_ok;

    assign w_acc      = i_rx_valid && r_rx_ready;
    assign w_n        = {i_rx_data, r_cnt_lo};
    assign w_last     = (32'(r_index) + 32'd1) == 32'(r_n);
    assign w_counting = (r_state == HDR_HI) || (r_state == DATA) || (r_state == CSUM);
    assign w_timeout  = (TIMEOUT_CYC != 0) && w_counting && !w_acc &&
                        ((32'(r_idle) + 32'd1) >= 32'(TIMEOUT_CYC));

    // A partial word must not leak into the next frame or survive an abort.
    assign w_clear = ((w_nxt == HDR_LO) && (r_state != HDR_LO)) ||
                     ((w_nxt == ERR) && (r_state != ERR));

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_byte_vld (w_acc && (r_state == DATA)),
        .i_byte_dat (i_rx_data),
        .o_word_vld (w_word_vld),
        .o_word_dat (w_word)
    );

`ifdef IMEM_LOADER_CSUM_EN
    byte_t r_xor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xor <= 8'd0;
        end else if ((r_state == DONE) && i_reload) begin
            r_xor <= 8'd0;
        end else if ((r_state == DATA) && w_acc) begin
            r_xor <= r_xor ^ i_rx_data;
        end
    end

    assign w_csum_ok = (i_rx_data == r_xor);
`else
    assign w_csum_ok = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            HDR_LO: begin
                if (w_acc) w_nxt = HDR_HI;
            end
            HDR_HI: begin
                if (w_acc) begin
                    if (w_n == '0)                              w_nxt = DONE;
                    else if (32'(w_n) > 32'(DEPTH_WORDS))       w_nxt = ERR;
                    else                                        w_nxt = DATA;
                end else if (w_timeout) begin
                    w_nxt = ERR;
                end
            end
            DATA: begin
                if (w_word_vld)     w_nxt = WRITE;
                else if (w_timeout) w_nxt = ERR;
            end
            WRITE: begin
`ifdef IMEM_LOADER_CSUM_EN
                w_nxt = w_last ? CSUM : DATA;
`else
                w_nxt = w_last ? DONE : DATA;
`endif
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                if (w_acc)          w_nxt = w_csum_ok ? DONE : ERR;
                else if (w_timeout) w_nxt = ERR;
            end
`endif
            DONE: begin
                if (i_reload) w_nxt = HDR_LO;
            end
            ERR: begin
                w_nxt = ERR;
            end
            default: begin
                w_nxt = ERR;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= HDR_LO;
            r_rx_ready <= 1'b1;
            r_im_we    <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_im_wd    <= '0;
            r_index    <= '0;
            r_cnt_lo   <= '0;
            r_n        <= '0;
            r_idle     <= '0;
        end else begin
            r_state    <= w_nxt;
            r_rx_ready <= rx_open(w_nxt);
            r_im_we    <= (w_nxt == WRITE);
            r_cpu_rst  <= (w_nxt != DONE);
            r_done     <= (w_nxt == DONE);
            r_err      <= (w_nxt == ERR);

            r_idle <= (w_acc || !w_counting) ? '0 : r_idle + 1'b1;

            if ((r_state == HDR_LO) && w_acc) r_cnt_lo <= i_rx_data;
            if ((r_state == HDR_HI) && w_acc) r_n      <= w_n;
            if (w_word_vld)                   r_im_wd  <= w_word;

            if (r_state == WRITE)                    r_index <= r_index + 1'b1;
            else if ((r_state == DONE) && i_reload)  r_index <= '0;
        end
    end

    assign o_rx_ready = r_rx_ready;
    assign o_im_we    = r_im_we;
    assign o_im_addr  = BASE_ADDR + ADDR_W'({r_index, 2'b00});
    assign o_im_wd    = r_im_wd;
    assign o_cpu_rst  = r_cpu_rst;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame table, directed timing/corner sequences, random frames vs a frame-level model.
// Latency: n/a.  Backpressure: byte sender waits on o_rx_ready with a bounded wait.
module tb_imem_loader;

    localparam int          DEPTH = 1024;
    localparam int          TMO   = 16;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk;
    logic        rst;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready;
    logic        i_reload;
    logic        o_im_we;
    logic [31:0] o_im_addr;
    logic [31:0] o_im_wd;
    logic        o_cpu_rst;
    logic        o_done;
    logic        o_err;

    imem_loader #(
        .ADDR_W      (32),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .o_rx_ready (o_rx_ready),
        .i_reload   (i_reload),
        .o_im_we    (o_im_we),
        .o_im_addr  (o_im_addr),
        .o_im_wd    (o_im_wd),
        .o_cpu_rst  (o_cpu_rst),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
    } wr_t;

    typedef struct {
        logic [95:0] b;
        int          len;
        bit          done;
        bit          err;
        int          nwe;
        logic [31:0] wd0;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx[$];
    wr_t         wq[$];
    wr_t         expq[$];
    bit          exp_done;
    bit          exp_err;
    vec_t        vt[4];

    always @(negedge clk) begin
        if (rst && o_im_we) wq.push_back({o_im_addr, o_im_wd});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_rx_valid = 1'b0;
        i_reload = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        wq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n;
        n = 0;
        ok = 0;
        i_rx_valid = 1'b1;
        i_rx_data = b;
        while (n < 50 && !ok) begin
            @(negedge clk);
            if (o_rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
            n++;
        end
        i_rx_valid = 1'b0;
    endtask

    function automatic int frame_n();
        if (tx.size() < 2) return -1;
        return int'(tx[0]) | (int'(tx[1]) << 8);
    endfunction

    function automatic logic [7:0] data_xor(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x ^= tx[2 + i];
        return x;
    endfunction

    task automatic add_csum();
`ifdef IMEM_LOADER_CSUM_EN
        int n;
        n = frame_n();
        if (n >= 1 && n <= DEPTH && tx.size() == 2 + 4 * n) tx.push_back(data_xor(n));
`endif
    endtask

    // Frame-level reference: what the image should look like once the frame is consumed.
    task automatic model();
        int n;
        logic [31:0] w;
        expq.delete();
        exp_done = 0;
        exp_err = 0;
        n = frame_n();
        if (n == 0) begin
            exp_done = 1;
        end else if (n > DEPTH) begin
            exp_err = 1;
        end else if (n > 0 && tx.size() >= 2 + 4 * n) begin
            for (int i = 0; i < n; i++) begin
                w = {tx[2 + 4*i + 3], tx[2 + 4*i + 2], tx[2 + 4*i + 1], tx[2 + 4*i]};
                expq.push_back({BASE + 32'(4 * i), w});
            end
`ifdef IMEM_LOADER_CSUM_EN
            if (tx.size() == 2 + 4 * n + 1) begin
                exp_done = (tx[2 + 4 * n] == data_xor(n));
                exp_err = !exp_done;
            end
`else
            exp_done = (tx.size() == 2 + 4 * n);
`endif
        end
    endtask

    task automatic send_tx(input int gap_max, input int reload_at, output bit all_ok);
        bit ok;
        all_ok = 1;
        for (int i = 0; i < tx.size(); i++) begin
            if (i == reload_at) begin
                i_reload = 1'b1;
                cyc();
                i_reload = 1'b0;
            end
            send_byte(tx[i], ok);
            if (!ok) all_ok = 0;
            repeat ($urandom_range(0, gap_max)) cyc();
        end
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (!(o_done || o_err) && k < 20) begin
            cyc();
            k++;
        end
    endtask

    task automatic compare_frame(input string tag);
        chk({tag, "_nwr"}, 64'(wq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < wq.size(); i++) begin
            chk({tag, "_addr"}, wq[i].addr, expq[i].addr);
            chk({tag, "_wd"}, wq[i].wd, expq[i].wd);
        end
        chk({tag, "_done"}, o_done, exp_done);
        chk({tag, "_err"}, o_err, exp_err);
        chk({tag, "_cpu_rst"}, o_cpu_rst, !exp_done);
        chk({tag, "_rx_ready"}, o_rx_ready, 1'b0);
    endtask

    task automatic random_frame(input int nmax);
        int n;
        n = $urandom_range(1, nmax);
        tx.delete();
        tx.push_back(8'(n));
        tx.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) tx.push_back(8'($urandom_range(0, 255)));
        add_csum();
    endtask

    initial begin
        bit ok;
        int k;

        rst = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data = 8'h00;
        i_reload = 1'b0;

        vt[0] = '{96'h00000000_00100073_00100513_0002, 10, 1'b1, 1'b0, 2, 32'h00100513};
        vt[1] = '{96'h0000, 2, 1'b1, 1'b0, 0, 32'h0};
        vt[2] = '{96'h0401, 2, 1'b0, 1'b1, 0, 32'h0};
        vt[3] = '{96'hDEADBEEF_0001, 6, 1'b1, 1'b0, 1, 32'hDEADBEEF};

        // Reset values while reset is held
        cyc();
        cyc();
        chk("rst_rx_ready", o_rx_ready, 1'b1);
        chk("rst_cpu_rst", o_cpu_rst, 1'b1);
        chk("rst_we", o_im_we, 1'b0);
        chk("rst_addr", o_im_addr, BASE);
        chk("rst_wd", o_im_wd, 32'h0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_err", o_err, 1'b0);

        // Table of frames
        for (int v = 0; v < 4; v++) begin
            do_reset();
            tx.delete();
            for (int i = 0; i < vt[v].len; i++) tx.push_back(vt[v].b[8*i +: 8]);
            add_csum();
            model();
            send_tx(2, -1, ok);
            chk("tbl_accept", ok, 1'b1);
            settle();
            chk("tbl_done", o_done, vt[v].done);
            chk("tbl_err", o_err, vt[v].err);
            chk("tbl_nwe", 64'(wq.size()), 64'(vt[v].nwe));
            if (vt[v].nwe > 0 && wq.size() > 0) chk("tbl_wd0", wq[0].wd, vt[v].wd0);
            compare_frame("tbl_model");
        end

        // Write-strobe and CPU-release timing on the two-word example
        do_reset();
        tx.delete();
        for (int i = 0; i < 10; i++) tx.push_back(vt[0].b[8*i +: 8]);
        for (int i = 0; i < 10; i++) begin
            send_byte(tx[i], ok);
            if (i == 5) begin
                chk("lat_we0", o_im_we, 1'b1);
                chk("lat_addr0", o_im_addr, 32'h0);
                chk("lat_wd0", o_im_wd, 32'h00100513);
            end
            if (i == 9) begin
                chk("lat_we1", o_im_we, 1'b1);
                chk("lat_addr1", o_im_addr, 32'h4);
                chk("lat_wd1", o_im_wd, 32'h00100073);
                chk("lat_cpu_rst_w", o_cpu_rst, 1'b1);
            end
        end
        cyc();
        chk("lat_we_drop", o_im_we, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
        chk("lat_csum_wait", o_cpu_rst, 1'b1);
        chk("lat_csum_ready", o_rx_ready, 1'b1);
        send_byte(8'h13 ^ 8'h05 ^ 8'h10 ^ 8'h73 ^ 8'h10, ok);
`endif
        chk("lat_cpu_rst", o_cpu_rst, 1'b0);
        chk("lat_done", o_done, 1'b1);

        // Empty image: DONE straight after cnt_hi
        do_reset();
        send_byte(8'h00, ok);
        send_byte(8'h00, ok);
        chk("n0_done", o_done, 1'b1);
        chk("n0_cpu_rst", o_cpu_rst, 1'b0);
        chk("n0_nwe", 64'(wq.size()), 64'd0);

        // No timeout while waiting for the header
        do_reset();
        repeat (3 * TMO) cyc();
        chk("hdr_idle_err", o_err, 1'b0);
        chk("hdr_idle_ready", o_rx_ready, 1'b1);

        // Timeout after two data bytes
        do_reset();
        tx = '{8'h01, 8'h00, 8'hAA, 8'h55};
        send_tx(0, -1, ok);
        k = 0;
        while (!o_err && k < 4 * TMO) begin
            cyc();
            k++;
        end
        chk("tmo_cycles", 64'(k), 64'(TMO + 0));
        chk("tmo_err", o_err, 1'b1);
        chk("tmo_nwe", 64'(wq.size()), 64'd0);
        chk("tmo_cpu_rst", o_cpu_rst, 1'b1);
        chk("tmo_ready", o_rx_ready, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
        do_reset();
        tx = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_tx(1, -1, ok);
        settle();
        chk("csum_good_done", o_done, 1'b1);
        chk("csum_good_err", o_err, 1'b0);
        do_reset();
        tx = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_tx(1, -1, ok);
        settle();
        chk("csum_bad_err", o_err, 1'b1);
        chk("csum_bad_cpu_rst", o_cpu_rst, 1'b1);
        chk("csum_bad_nwe", 64'(wq.size()), 64'd1);
`endif

        // Async reset during a WRITE cycle, then a fresh frame from address 0
        do_reset();
        tx = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 6; i++) send_byte(tx[i], ok);
        chk("arst_pre_we", o_im_we, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_we", o_im_we, 1'b0);
        chk("arst_addr", o_im_addr, BASE);
        chk("arst_wd", o_im_wd, 32'h0);
        chk("arst_ready", o_rx_ready, 1'b1);
        chk("arst_cpu_rst", o_cpu_rst, 1'b1);
        cyc();
        rst = 1'b1;
        wq.delete();
        random_frame(3);
        model();
        send_tx(2, -1, ok);
        settle();
        compare_frame("arst_next");

        // Reload pulse mid-header must be ignored
        do_reset();
        random_frame(2);
        model();
        send_tx(1, 1, ok);
        settle();
        compare_frame("reload_ign");

        // Random frames chained by reload
        do_reset();
        for (int f = 0; f < 6; f++) begin
            wq.delete();
            random_frame(5);
            model();
            send_tx(3, -1, ok);
            chk("rnd_accept", ok, 1'b1);
            settle();
            compare_frame("rnd");
            i_reload = 1'b1;
            cyc();
            i_reload = 1'b0;
            chk("rld_cpu_rst", o_cpu_rst, 1'b1);
            chk("rld_ready", o_rx_ready, 1'b1);
            chk("rld_done", o_done, 1'b0);
            chk("rld_addr", o_im_addr, BASE);
        end

        // Largest legal image
        do_reset();
        tx.delete();
        tx.push_back(8'(DEPTH));
        tx.push_back(8'(DEPTH >> 8));
        for (int i = 0; i < 4 * DEPTH; i++) tx.push_back(8'($urandom_range(0, 255)));
        add_csum();
        model();
        send_tx(0, -1, ok);
        settle();
        compare_frame("depth_max");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
